rom_burst_reader: RTL and testbench

Initiator-side sequencer for the team's synchronous ROM (1-cycle registered read, tri-stated output when not enabled). Given a base address and a length, it walks consecutive ROM addresses, tracks the one-cycle read latency, captures each word into a 2-entry output buffer and presents it as a valid/ready stream with a last-beat marker. It sits between the ROM and any consumer (DMA, table loader) that needs burst reads with backpressure.

---
 rtl/rom_burst_reader.sv | 169 ++++++++++++++++
 tb/tb_rom_burst_reader.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_burst_reader.sv
`default_nettype none
// ============================================================================
// rom_burst_reader: walks a synchronous ROM for a burst and streams the words
// through a 2-entry valid/ready buffer. Optional: ROM_BURST_READER_CHECKSUM_EN.
// Revision: 1.0
// ============================================================================
module rom_burst_reader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_enable,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
`ifdef ROM_BURST_READER_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] checksum
`endif
);

  localparam logic [1:0]          S_IDLE  = 2'd0;
  localparam logic [1:0]          S_READ  = 2'd1;
  localparam logic [1:0]          S_DRAIN = 2'd2;
  localparam logic [ADDR_WIDTH:0] C_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH:0]   issued_q, issued_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_last_q, inflight_last_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] mem_q [2];
  logic [DATA_WIDTH-1:0] mem_d [2];
  logic [1:0]            last_q, last_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;

  logic                  w_valid;
  logic                  w_pop;
  logic [2:0]            w_occupancy;
  logic                  w_issue;
  logic                  w_issue_last;
  logic                  w_start_ok;
  logic                  w_finish;

  assign w_valid      = (count_q != 2'd0);
  assign w_pop        = w_valid & out_ready;
  // Words held plus words already requested, net of the one leaving this cycle.
  assign w_occupancy  = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, w_pop};
  assign w_issue      = (state_q == S_READ) && (w_occupancy < 3'd2);
  assign w_issue_last = ((issued_q + C_ONE) == len_q);
  assign w_start_ok   = (state_q == S_IDLE) && start;
  assign w_finish     = (state_q == S_DRAIN) && !inflight_q && (count_d == 2'd0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start && (length != '0)) state_d = S_READ;
      S_READ:  if (w_issue && w_issue_last) state_d = S_DRAIN;
      S_DRAIN: if (w_finish)                state_d = S_IDLE;
      default:                              state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy       = (state_q != S_IDLE);
    done       = done_q;
    rom_enable = w_issue;
    rom_addr   = base_q + issued_q[ADDR_WIDTH-1:0];
    out_valid  = w_valid;
    out_data   = mem_q[rd_ptr_q];
    out_last   = w_valid & last_q[rd_ptr_q];
  end

  // Datapath next values
  always_comb begin
    base_d          = base_q;
    len_d           = len_q;
    issued_d        = issued_q;
    if (w_start_ok && (length != '0)) begin
      base_d   = base_addr;
      len_d    = length;
      issued_d = '0;
    end else if (w_issue) begin
      issued_d = issued_q + C_ONE;
    end
    inflight_d      = w_issue;
    inflight_last_d = w_issue && w_issue_last;
    mem_d           = mem_q;
    last_d          = last_q;
    // rom_data is only meaningful the cycle after an issue.
    if (inflight_q) begin
      mem_d[wr_ptr_q]  = rom_data;
      last_d[wr_ptr_q] = inflight_last_q;
    end
    wr_ptr_d = wr_ptr_q ^ inflight_q;
    rd_ptr_d = rd_ptr_q ^ w_pop;
    count_d  = count_q + {1'b0, inflight_q} - {1'b0, w_pop};
    done_d   = (w_start_ok && (length == '0)) || w_finish;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q          <= '0;
      len_q           <= '0;
      issued_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
      mem_q[0]        <= '0;
      mem_q[1]        <= '0;
      last_q          <= '0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      count_q         <= '0;
    end else begin
      base_q          <= base_d;
      len_q           <= len_d;
      issued_q        <= issued_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      done_q          <= done_d;
      mem_q           <= mem_d;
      last_q          <= last_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
    end
  end

`ifdef ROM_BURST_READER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (w_start_ok)  checksum_d = '0;
    else if (w_pop)  checksum_d = checksum_q ^ mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (rst) checksum_q <= '0;
    else     checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rom_burst_reader.sv
`default_nettype none
// Directed bench for rom_burst_reader: a behavioural ROM plus per-scenario
// tasks that drive bursts and compare against hand-derived expectations.
module tb_rom_burst_reader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  base_addr;
  logic [8:0]  length;
  logic        busy;
  logic        done;
  logic [7:0]  rom_addr;
  logic        rom_enable;
  logic [31:0] rom_data;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
`ifdef ROM_BURST_READER_CHECKSUM_EN
  logic [31:0] checksum;
  logic [31:0] ck_at_done;
`endif

  int errors = 0;
  int checks = 0;

  rom_burst_reader #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .rom_addr  (rom_addr),
    .rom_enable(rom_enable),
    .rom_data  (rom_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
`ifdef ROM_BURST_READER_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents: three fixed words, then a per-address pattern.
  function automatic logic [31:0] rom_word(input logic [7:0] a);
    case (a)
      8'h00:   return 32'hDEADBEEF;
      8'h01:   return 32'h12345678;
      8'h02:   return 32'hABCDEF01;
      default: return {a, ~a, 8'h3C, a ^ 8'h5A};
    endcase
  endfunction

  // Registered ROM; an obviously wrong word stands in for the floating bus.
  logic [31:0] rom_q;
  logic        rom_en_q;
  always @(posedge clk) begin
    rom_en_q <= rom_enable;
    if (rom_enable) rom_q <= rom_word(rom_addr);
  end
  assign rom_data = rom_en_q ? rom_q : 32'hBAD0_BAD0;

  // Observations collected by run_burst
  logic [31:0] obs_data [300];
  logic        obs_last [300];
  int          obs_cyc  [300];
  logic [7:0]  obs_addr [300];
  int n_beats, n_en, n_done, n_valid, first_en_c, first_busy_c, done_c;
  int stall_bad, credit_bad;
  logic busy_at_done;

  // Drives one burst (start in cycle 0) and records what the DUT does.
  // Called and returns at posedge+1.
  task automatic run_burst(input logic [7:0] b, input logic [8:0] l, input int mode,
                           input int extra_start_c, input int max_c);
    logic [5:0]  pat = 6'b101001;
    int          issued = 0;
    int          accepted = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic        pop;
    n_beats = 0; n_en = 0; n_done = 0; n_valid = 0;
    first_en_c = -1; first_busy_c = -1; done_c = -1;
    stall_bad = 0; credit_bad = 0; busy_at_done = 1'b1;
    for (int c = 0; c < max_c; c++) begin
      start     = (c == 0) || (c == extra_start_c);
      base_addr = (c == 0) ? b : 8'h00;
      length    = (c == 0) ? l : 9'd5;
      out_ready = (mode == 0) ? 1'b1 : pat[c % 6];
      @(negedge clk);
      if (prev_stall && (!out_valid || out_data !== prev_data)) stall_bad++;
      pop = out_valid && out_ready;
      if (rom_enable && ((issued - accepted - int'(pop)) >= 2)) credit_bad++;
      if (out_valid) n_valid++;
      if (rom_enable) begin
        if (n_en < 300) obs_addr[n_en] = rom_addr;
        if (n_en == 0) first_en_c = c;
        n_en++;
        issued++;
      end
      if (busy && first_busy_c < 0) first_busy_c = c;
      if (pop) begin
        if (n_beats < 300) begin
          obs_data[n_beats] = out_data;
          obs_last[n_beats] = out_last;
          obs_cyc[n_beats]  = c;
        end
        n_beats++;
        accepted++;
      end
      if (done) begin
        n_done++;
        done_c = c;
        busy_at_done = busy;
`ifdef ROM_BURST_READER_CHECKSUM_EN
        ck_at_done = checksum;
`endif
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      @(posedge clk); #1;
      if (done_c >= 0 && c >= done_c + 2) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if ({busy, done, rom_enable, out_valid, out_last} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, rom_enable, out_valid, out_last});
    end
    checks++; if (rom_addr !== 8'h00) begin
      errors++; $display("FAIL reset_rom_addr: got %h expected 00", rom_addr);
    end
    checks++; if (out_data !== 32'h0) begin
      errors++; $display("FAIL reset_out_data: got %h expected 0", out_data);
    end
`ifdef ROM_BURST_READER_CHECKSUM_EN
    checks++; if (checksum !== 32'h0) begin
      errors++; $display("FAIL reset_checksum: got %h expected 0", checksum);
    end
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [31:0] exp_d [3] = '{32'hDEADBEEF, 32'h12345678, 32'hABCDEF01};
    run_burst(8'h00, 9'd3, 0, -1, 20);
    checks++; if (first_busy_c !== 1 || first_en_c !== 1) begin
      errors++; $display("FAIL basic_first_cycle: got busy@%0d en@%0d expected 1,1", first_busy_c, first_en_c);
    end
    checks++; if (n_beats !== 3) begin
      errors++; $display("FAIL basic_beats: got %0d expected 3", n_beats);
    end
    for (int i = 0; i < 3; i++) begin
      checks++; if (obs_data[i] !== exp_d[i] || obs_cyc[i] !== 3 + i || obs_last[i] !== (i == 2)) begin
        errors++; $display("FAIL basic_beat[%0d]: got %h cyc %0d last %b expected %h cyc %0d last %b",
                           i, obs_data[i], obs_cyc[i], obs_last[i], exp_d[i], 3 + i, (i == 2));
      end
      checks++; if (obs_addr[i] !== 8'(i)) begin
        errors++; $display("FAIL basic_addr[%0d]: got %h expected %h", i, obs_addr[i], 8'(i));
      end
    end
    checks++; if (done_c !== 6 || n_done !== 1 || busy_at_done !== 1'b0) begin
      errors++; $display("FAIL basic_done: got cyc %0d n %0d busy %b expected cyc 6 n 1 busy 0", done_c, n_done, busy_at_done);
    end
`ifdef ROM_BURST_READER_CHECKSUM_EN
    checks++; if (ck_at_done !== 32'h67540796) begin
      errors++; $display("FAIL basic_checksum: got %h expected 67540796", ck_at_done);
    end
`endif
  endtask

  task automatic test_wrap();
    logic [7:0] exp_a [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    run_burst(8'hFE, 9'd4, 0, -1, 20);
    checks++; if (n_beats !== 4 || n_en !== 4) begin
      errors++; $display("FAIL wrap_count: got beats %0d reads %0d expected 4,4", n_beats, n_en);
    end
    for (int i = 0; i < 4; i++) begin
      checks++; if (obs_addr[i] !== exp_a[i] || obs_data[i] !== rom_word(exp_a[i]) || obs_last[i] !== (i == 3)) begin
        errors++; $display("FAIL wrap_beat[%0d]: got addr %h data %h last %b expected addr %h data %h last %b",
                           i, obs_addr[i], obs_data[i], obs_last[i], exp_a[i], rom_word(exp_a[i]), (i == 3));
      end
    end
  endtask

  task automatic test_backpressure();
    run_burst(8'h10, 9'd3, 1, -1, 40);
    checks++; if (n_beats !== 3 || n_done !== 1) begin
      errors++; $display("FAIL bp_count: got beats %0d done %0d expected 3,1", n_beats, n_done);
    end
    for (int i = 0; i < 3; i++) begin
      checks++; if (obs_data[i] !== rom_word(8'h10 + 8'(i)) || obs_last[i] !== (i == 2)) begin
        errors++; $display("FAIL bp_beat[%0d]: got %h last %b expected %h last %b",
                           i, obs_data[i], obs_last[i], rom_word(8'h10 + 8'(i)), (i == 2));
      end
    end
    checks++; if (stall_bad !== 0) begin
      errors++; $display("FAIL bp_stable: got %0d unstable stall cycles expected 0", stall_bad);
    end
    checks++; if (credit_bad !== 0) begin
      errors++; $display("FAIL bp_credit: got %0d over-credit reads expected 0", credit_bad);
    end
  endtask

  task automatic test_zero_length();
    run_burst(8'h40, 9'd0, 0, -1, 10);
    checks++; if (done_c !== 1 || n_done !== 1) begin
      errors++; $display("FAIL zero_done: got cyc %0d n %0d expected cyc 1 n 1", done_c, n_done);
    end
    checks++; if (n_valid !== 0 || n_en !== 0 || first_busy_c !== -1) begin
      errors++; $display("FAIL zero_quiet: got valid %0d reads %0d busy@%0d expected 0,0,-1", n_valid, n_en, first_busy_c);
    end
  endtask

  task automatic test_reset_mid_burst();
    int pops = 0;
    int bad = 0;
    for (int c = 0; c < 5; c++) begin
      start = (c == 0); base_addr = 8'h00; length = 9'd8; out_ready = 1'b1;
      @(negedge clk);
      if (out_valid && out_ready) pops++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    checks++; if (pops !== 2) begin
      errors++; $display("FAIL midrst_pre_beats: got %0d expected 2", pops);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({busy, done, rom_enable, out_valid, out_last} !== 5'b0 || rom_addr !== 8'h00 || out_data !== 32'h0) begin
      errors++; $display("FAIL midrst_outputs: got ctrl %b addr %h data %h expected 00000 00 0",
                         {busy, done, rom_enable, out_valid, out_last}, rom_addr, out_data);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done || out_valid || rom_enable) bad++;
    end
    @(posedge clk); #1;
    checks++; if (bad !== 0) begin
      errors++; $display("FAIL midrst_quiet: got %0d active cycles expected 0", bad);
    end
    run_burst(8'h00, 9'd1, 0, -1, 20);
    checks++; if (n_beats !== 1 || obs_data[0] !== 32'hDEADBEEF || obs_last[0] !== 1'b1 || n_done !== 1) begin
      errors++; $display("FAIL midrst_restart: got beats %0d data %h last %b done %0d expected 1 DEADBEEF 1 1",
                         n_beats, obs_data[0], obs_last[0], n_done);
    end
  endtask

  task automatic test_full_wrap();
    int bad = 0;
    int first_bad = -1;
    run_burst(8'h80, 9'd256, 0, 50, 300);
    checks++; if (n_beats !== 256 || n_en !== 256) begin
      errors++; $display("FAIL full_count: got beats %0d reads %0d expected 256,256", n_beats, n_en);
    end
    for (int i = 0; i < 256; i++) begin
      if (obs_cyc[i] !== 3 + i || obs_addr[i] !== 8'h80 + 8'(i) ||
          obs_data[i] !== rom_word(8'h80 + 8'(i)) || obs_last[i] !== (i == 255)) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    checks++; if (bad !== 0) begin
      errors++; $display("FAIL full_beats: got %0d bad beats (first %0d) expected 0", bad, first_bad);
    end
    checks++; if (done_c !== 259 || n_done !== 1) begin
      errors++; $display("FAIL full_done: got cyc %0d n %0d expected cyc 259 n 1", done_c, n_done);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_length();
    test_reset_mid_burst();
    test_full_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
